// File: rtl/window_fetcher_arb_pkg.sv
// Shared types and constants for the two-source window_fetcher arbiter.
package window_fetcher_arb_pkg;

    localparam int ARB_NUM_SOURCES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    // Width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/window_fetcher_arbiter_raster_counter.sv
// raster_counter: column/row position of a raster scan. Advances one pixel
// per enabled cycle, wraps at the end of each row and at the end of the frame.
// last_o flags the final pixel of the frame at the current position.
module raster_counter
    import window_fetcher_arb_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    localparam int COL_WIDTH   = clog2_min1(IMAGE_WIDTH),
    localparam int ROW_WIDTH   = clog2_min1(IMAGE_HEIGHT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    output logic [COL_WIDTH-1:0] col_o,
    output logic [ROW_WIDTH-1:0] row_o,
    output logic                 last_o
);

    localparam logic [COL_WIDTH-1:0] COL_MAX = COL_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_MAX = ROW_WIDTH'(IMAGE_HEIGHT - 1);

    logic [COL_WIDTH-1:0] r_col;
    logic [ROW_WIDTH-1:0] r_row;
    logic                 w_col_last;
    logic                 w_row_last;

    assign w_col_last = (r_col == COL_MAX);
    assign w_row_last = (r_row == ROW_MAX);

    // Raster position: column first, row on column wrap, both clear at frame end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (en_i) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign col_o  = r_col;
    assign row_o  = r_row;
    assign last_o = w_col_last & w_row_last;

endmodule

// File: rtl/window_fetcher_arbiter.sv
// window_fetcher_arbiter: grants one of two raster sources for a whole frame,
// forwards its beats with one registered cycle of latency using internally
// generated coordinates, then idles DRAIN_CYCLES cycles before the next grant.
// Optional feature macro: WINDOW_FETCHER_ARB_COORD_CHECK_EN enables a sticky
// error_o when a source's col_i/row_i disagree with the expected position.
module window_fetcher_arbiter
    import window_fetcher_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int DRAIN_CYCLES = 16,
    localparam int COL_WIDTH   = clog2_min1(IMAGE_WIDTH),
    localparam int ROW_WIDTH   = clog2_min1(IMAGE_HEIGHT)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_WIDTH-1:0]      data_i  [ARB_NUM_SOURCES],
    input  logic [COL_WIDTH-1:0]       col_i   [ARB_NUM_SOURCES],
    input  logic [ROW_WIDTH-1:0]       row_i   [ARB_NUM_SOURCES],
    input  logic [ARB_NUM_SOURCES-1:0] valid_i,
    output logic [ARB_NUM_SOURCES-1:0] ready_o,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic [COL_WIDTH-1:0]       col_o,
    output logic [ROW_WIDTH-1:0]       row_o,
    output logic                       valid_o,
    output logic                       grant_o,
    output logic                       busy_o,
    output logic                       error_o
);

    localparam int DRAIN_W = clog2_min1(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    arb_state_t                 r_state;
    arb_state_t                 w_state_nxt;
    logic                       r_grant;
    logic                       w_grant_nxt;
    // Source served by the most recent completed frame; loses the next tie.
    logic                       r_last_served;
    logic [DRAIN_W-1:0]         r_drain;
    logic [ARB_NUM_SOURCES-1:0] w_ready;
    logic                       w_accept;
    logic                       w_frame_end;

    logic [COL_WIDTH-1:0]       w_cnt_col;
    logic [ROW_WIDTH-1:0]       w_cnt_row;
    logic                       w_cnt_last;

    logic [DATA_WIDTH-1:0]      r_data;
    logic [COL_WIDTH-1:0]       r_col;
    logic [ROW_WIDTH-1:0]       r_row;
    logic                       r_valid;

    raster_counter #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT)
    ) u_raster (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (w_accept),
        .col_o  (w_cnt_col),
        .row_o  (w_cnt_row),
        .last_o (w_cnt_last)
    );

    assign w_frame_end = w_accept & w_cnt_last;

    // Next-state, grant selection and per-source ready.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ready     = '0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|valid_i) begin
                    w_state_nxt = ST_GRANT;
                    if (&valid_i) begin
                        w_grant_nxt = ~r_last_served;
                    end else begin
                        w_grant_nxt = ~valid_i[0];
                    end
                end
            end
            ST_GRANT: begin
                w_ready[r_grant] = 1'b1;
                w_accept         = valid_i[r_grant];
                if (w_accept && w_cnt_last) begin
                    w_state_nxt = (DRAIN_CYCLES == 0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, grant and round-robin pointer; reset leaves source 0 favoured.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_grant       <= 1'b0;
            r_last_served <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_frame_end) begin
                r_last_served <= r_grant;
            end
        end
    end

    // Drain down-counter: loaded on the last beat, counts to zero in DRAIN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drain <= '0;
        end else if (w_frame_end) begin
            r_drain <= DRAIN_LOAD;
        end else if (r_state == ST_DRAIN && r_drain != '0) begin
            r_drain <= r_drain - 1'b1;
        end
    end

    // Output register toward the fetcher; coordinates come from the counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_data <= data_i[r_grant];
                r_col  <= w_cnt_col;
                r_row  <= w_cnt_row;
            end
        end
    end

`ifdef WINDOW_FETCHER_ARB_COORD_CHECK_EN
    logic r_error;

    // Sticky flag: granted source's coordinates disagree with the raster position.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_error <= 1'b0;
        end else if (w_accept &&
                     (col_i[r_grant] != w_cnt_col || row_i[r_grant] != w_cnt_row)) begin
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;
`else
    // Source coordinates carry no meaning without checking; folded to a constant 0.
    logic w_coord_ignored;
    assign w_coord_ignored = ^{col_i[0], col_i[1], row_i[0], row_i[1]};
    assign error_o         = w_coord_ignored & 1'b0;
`endif

    assign ready_o = w_ready;
    assign data_o  = r_data;
    assign col_o   = r_col;
    assign row_o   = r_row;
    assign valid_o = r_valid;
    assign grant_o = r_grant;
    assign busy_o  = (r_state != ST_IDLE);

endmodule
